// File: rtl/fwd_pkg.sv
// fwd_pkg: slot tag type and constants shared by the forwarding/hazard unit
package fwd_pkg;
  // rd is held at a fixed width so that any REG_AW up to RD_W fits in a slot tag
  localparam int RD_W = 8;
  localparam logic [RD_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic valid;
    logic wr_en;
    logic [RD_W-1:0] rd;
    logic is_load;
  } slot_t;
  localparam slot_t SLOT_NONE = '0;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-stage operand/tag bundle between the pipeline and the forwarding unit
interface fwd_hazard_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
);
  logic id_valid, id_flush, id_uses_rs, id_uses_rt, id_jr, id_wr_en, id_is_load;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, rs_data_out, rt_data_out;
  logic [DEPTH*DATA_W-1:0] stage_data;
  logic stall;
  logic [15:0] stall_count;
  modport master (
    output id_valid, id_flush, id_uses_rs, id_uses_rt, id_jr, id_wr_en, id_is_load,
    output id_rs, id_rt, id_rd, id_rs_data, id_rt_data, stage_data,
    input  rs_data_out, rt_data_out, stall, stall_count
  );
  modport slave (
    input  id_valid, id_flush, id_uses_rs, id_uses_rt, id_jr, id_wr_en, id_is_load,
    input  id_rs, id_rt, id_rd, id_rs_data, id_rt_data, stage_data,
    output rs_data_out, rt_data_out, stall, stall_count
  );
endinterface

// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel: youngest-producer match, availability check and operand mux for one source
module fwd_operand_sel import fwd_pkg::*; #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 3,
  parameter int LOAD_SLOT = 2,
  parameter int JR_SLOT   = 1
) (
  input  slot_t [DEPTH-1:0]        slots,
  input  logic [DEPTH*DATA_W-1:0]  stage_data,
  input  logic [REG_AW-1:0]        r,
  input  logic                     uses,
  input  logic                     jr,
  input  logic [DATA_W-1:0]        rf_data,
  output logic [DATA_W-1:0]        data,
  output logic                     hazard
);
  logic [RD_W-1:0] r_ext;
  assign r_ext = RD_W'(r);
  // scanning oldest to youngest lets the lowest matching slot overwrite the result last
  always_comb begin
    data = rf_data;
    hazard = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (uses && r_ext != REG_ZERO && slots[i].valid && slots[i].wr_en && slots[i].rd == r_ext) begin
        hazard = (slots[i].is_load && i < LOAD_SLOT) || (jr && i < JR_SLOT);
        data = hazard ? rf_data : stage_data[i*DATA_W +: DATA_W];
      end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks in-flight destination tags, forwards operands into ID and raises stalls
module fwd_hazard_unit import fwd_pkg::*; #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 3,
  parameter int LOAD_SLOT = 2,
  parameter int JR_SLOT   = 1
) (
  input logic clk,
  input logic rst,
  fwd_hazard_unit_if.slave bus
);
  slot_t [DEPTH-1:0] slots;
  slot_t id_tag;
  logic rs_haz, rt_haz, issue;
  logic [15:0] count;
  assign id_tag = '{valid: 1'b1, wr_en: bus.id_wr_en, rd: RD_W'(bus.id_rd), is_load: bus.id_is_load};
  assign bus.stall = bus.id_valid && !bus.id_flush && (rs_haz || rt_haz);
  assign issue = bus.id_valid && !bus.id_flush && !bus.stall;
  assign bus.stall_count = count;
  // a stalled or flushed ID instruction leaves a bubble in slot 0
  always_ff @(posedge clk)
    if (rst) begin
      slots <= '0;
      count <= '0;
    end else begin
      slots <= {slots[DEPTH-2:0], issue ? id_tag : SLOT_NONE};
      count <= (bus.stall && count != 16'hFFFF) ? count + 16'd1 : count;
    end
  fwd_operand_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_SLOT(LOAD_SLOT), .JR_SLOT(JR_SLOT)) u_rs (
    .slots(slots), .stage_data(bus.stage_data), .r(bus.id_rs), .uses(bus.id_uses_rs), .jr(bus.id_jr),
    .rf_data(bus.id_rs_data), .data(bus.rs_data_out), .hazard(rs_haz)
  );
  fwd_operand_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_SLOT(LOAD_SLOT), .JR_SLOT(JR_SLOT)) u_rt (
    .slots(slots), .stage_data(bus.stage_data), .r(bus.id_rt), .uses(bus.id_uses_rt), .jr(1'b0),
    .rf_data(bus.id_rt_data), .data(bus.rt_data_out), .hazard(rt_haz)
  );
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed and random checks against an issue-history model of the pipeline
module tb_fwd_hazard_unit;
  localparam int DW = 32, AW = 5, D = 3, LS = 2, JS = 1;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  fwd_hazard_unit_if #(.DATA_W(DW), .REG_AW(AW), .DEPTH(D)) bus ();
  fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .DEPTH(D), .LOAD_SLOT(LS), .JR_SLOT(JS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int checks = 0, failures = 0, exp_cnt = 0;
  typedef struct {int age; logic wr; logic [AW-1:0] rd; logic ld;} rec_t;
  rec_t hist[$];
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic resolve(input logic [AW-1:0] r, input logic uses, input logic jr,
                         input logic [DW-1:0] rf, output logic [DW-1:0] data, output logic haz);
    int best = -1;
    logic ld = 1'b0;
    data = rf;
    haz = 1'b0;
    if (!uses || r == '0) return;
    foreach (hist[k])
      if (hist[k].wr && hist[k].rd == r && (best < 0 || hist[k].age < best)) begin
        best = hist[k].age;
        ld = hist[k].ld;
      end
    if (best < 0) return;
    if ((ld && best < LS) || (jr && best < JS)) haz = 1'b1;
    else data = bus.stage_data[best*DW +: DW];
  endtask
  task automatic cycle(string tag);
    logic [DW-1:0] ers, ert;
    logic hrs, hrt, es;
    #2;
    resolve(bus.id_rs, bus.id_uses_rs, bus.id_jr, bus.id_rs_data, ers, hrs);
    resolve(bus.id_rt, bus.id_uses_rt, 1'b0, bus.id_rt_data, ert, hrt);
    es = bus.id_valid && !bus.id_flush && (hrs || hrt);
    chk({tag, ".rs"}, bus.rs_data_out, ers);
    chk({tag, ".rt"}, bus.rt_data_out, ert);
    chk({tag, ".stall"}, 32'(bus.stall), 32'(es));
    chk({tag, ".count"}, 32'(bus.stall_count), 32'(exp_cnt));
    @(posedge clk);
    if (rst) begin
      hist.delete();
      exp_cnt = 0;
    end else begin
      if (es && exp_cnt < 65535) exp_cnt++;
      foreach (hist[k]) hist[k].age++;
      while (hist.size() > 0 && hist[$].age >= D) void'(hist.pop_back());
      if (bus.id_valid && !bus.id_flush && !es)
        hist.push_front('{0, bus.id_wr_en, bus.id_rd, bus.id_is_load});
    end
    #1;
  endtask
  task automatic set_id(logic v, logic f, logic [AW-1:0] rs, logic [AW-1:0] rt, logic urs, logic urt,
                        logic jr, logic wr, logic [AW-1:0] rd, logic ld);
    bus.id_valid = v; bus.id_flush = f; bus.id_rs = rs; bus.id_rt = rt;
    bus.id_uses_rs = urs; bus.id_uses_rt = urt; bus.id_jr = jr;
    bus.id_wr_en = wr; bus.id_rd = rd; bus.id_is_load = ld;
  endtask
  task automatic set_stage(logic [DW-1:0] d0, logic [DW-1:0] d1, logic [DW-1:0] d2);
    bus.stage_data = {d2, d1, d0};
  endtask
  initial begin
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.id_rs_data = 32'h5A5A; bus.id_rt_data = 32'hA5A5;
    set_stage(0, 0, 0);
    @(posedge clk); #1;
    cycle("reset");
    rst = 1'b0;
    cycle("idle");
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 5, 0); cycle("alu_r5");
    set_id(1, 0, 5, 0, 1, 0, 0, 0, 0, 0); set_stage(32'h1234, 0, 0);
    #1; chk("alu_fwd_rs", bus.rs_data_out, 32'h1234); chk("alu_fwd_stall", 32'(bus.stall), 0);
    cycle("alu_fwd");
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 5, 0); cycle("w5_old");
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 7, 0); cycle("w7");
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 5, 0); cycle("w5_new");
    set_id(1, 0, 0, 5, 0, 1, 0, 0, 0, 0); set_stage(32'hAAAA, 32'h7777, 32'hBBBB);
    #1; chk("youngest_rt", bus.rt_data_out, 32'hAAAA);
    cycle("youngest");
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 8, 1); set_stage(0, 0, 32'hCAFE); cycle("load_r8");
    set_id(1, 0, 8, 9, 1, 1, 0, 1, 9, 0); bus.id_rt_data = 32'h9999;
    #1; chk("lu_stall1", 32'(bus.stall), 1); cycle("lu1");
    #1; chk("lu_stall2", 32'(bus.stall), 1); chk("lu_bubble_rt", bus.rt_data_out, 32'h9999); cycle("lu2");
    #1; chk("lu_release", 32'(bus.stall), 0); chk("lu_rs", bus.rs_data_out, 32'hCAFE);
    chk("lu_count", 32'(bus.stall_count), 2); cycle("lu3");
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 31, 0); cycle("alu_r31");
    set_id(1, 0, 31, 0, 1, 0, 1, 0, 0, 0); set_stage(0, 32'h3131, 0);
    #1; chk("jr_stall", 32'(bus.stall), 1); cycle("jr1");
    #1; chk("jr_release", 32'(bus.stall), 0); chk("jr_rs", bus.rs_data_out, 32'h3131); cycle("jr2");
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle("alu_r0");
    set_id(1, 0, 0, 0, 1, 1, 0, 0, 0, 0); set_stage(32'hFFFF, 32'hFFFF, 32'hFFFF);
    bus.id_rs_data = 0; bus.id_rt_data = 0;
    #1; chk("r0_rs", bus.rs_data_out, 0); chk("r0_rt", bus.rt_data_out, 0); chk("r0_stall", 32'(bus.stall), 0);
    cycle("r0");
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 10, 1); cycle("load_r10");
    set_id(1, 0, 10, 0, 1, 0, 0, 1, 12, 0);
    #1; chk("fl_pre_stall", 32'(bus.stall), 1); cycle("fl1");
    bus.id_flush = 1'b1;
    #1; chk("fl_masked", 32'(bus.stall), 0); cycle("fl2");
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 11, 1); cycle("load_r11");
    set_id(1, 0, 11, 0, 1, 0, 0, 1, 12, 0); rst = 1'b1;
    #1; chk("rst_pre_stall", 32'(bus.stall), 1); cycle("rst_mid");
    rst = 1'b0;
    #1; chk("rst_stall", 32'(bus.stall), 0); chk("rst_count", 32'(bus.stall_count), 0); cycle("post_rst");
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_id(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
             AW'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0));
      bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
      set_stage($urandom, $urandom, $urandom);
      cycle("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
